// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin WISHBONE arbiter.
// Holds the FSM state encoding and the index-width helper.
package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request above the
// last-grant index, wrapping around, one-hot result.
module rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    always_comb begin : pick
        int unsigned   sum;
        logic [LW-1:0] idx;
        gnt_o   = '0;
        valid_o = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            sum = int'(last_i) + i;
            idx = LW'(sum % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin WISHBONE arbiter with per-grant stall watchdog.
// A grant spans a whole bus cycle; owners are one idle cycle apart.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [ADDRESS_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                timeout_o
);

    localparam int LW = idx_width(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

    arb_state_e state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0] gidx_q, gidx_d;
    logic [LW-1:0] last_q, last_d;

    logic [NUM_MASTERS-1:0] pick;
    logic                   pick_vld;
    logic [LW-1:0]          pick_idx;

    logic                     g_cyc;
    logic                     g_stb;
    logic                     g_we;
    logic [ADDRESS_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0]    g_dat;
    logic [SW-1:0]            g_sel;
    logic                     fire;

    rr_pick #(
        .N  (NUM_MASTERS),
        .LW (LW)
    ) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .gnt_o   (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (pick[k]) begin
                pick_idx = LW'(k);
            end
        end
    end

    assign g_cyc = m_cyc_i[gidx_q];
    assign g_stb = m_stb_i[gidx_q];
    assign g_we  = m_we_i[gidx_q];
    assign g_adr = m_adr_i[int'(gidx_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign g_dat = m_dat_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign g_sel = m_sel_i[int'(gidx_q)*SW +: SW];

    // Watchdog counts stalled strobe cycles; an ack in the limit cycle wins.
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
            TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

        logic                     stall;
        logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

        assign stall = (state_q == ST_OWN) && g_cyc && g_stb
                    && !s_ack_i && !s_err_i;
        assign fire  = stall && (wd_q == WD_LIMIT);

        always_comb begin
            wd_d = '0;
            if (stall && !fire) begin
                wd_d = wd_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_d;
            end
        end
    end else begin : g_no_wd
        assign fire = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_OWN;
                    grant_d = pick;
                    gidx_d  = pick_idx;
                end
            end
            ST_OWN: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end else if (fire) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state_q == ST_OWN) begin
            s_cyc_o = g_cyc && !fire;
            s_stb_o = g_stb && !fire;
            s_we_o  = g_we;
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
            m_err_o = grant_q & {NUM_MASTERS{s_err_i || fire}};
        end
    end

    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = fire;

endmodule
